// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin wormhole arbiter draining N_PORTS input FIFOs onto one link.
// The grant locks from head to tail flit; the pointer rotates past the winner after each tail.
module fifo_rr_arbiter #(
    parameter int N_PORTS = 5,
    parameter int DATA_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_PORTS-1:0]          fifo_empty_i,
    input  logic [N_PORTS*DATA_W-1:0]   fifo_data_i,
    output logic [N_PORTS-1:0]          fifo_rd_en_o,
    input  logic                        ready_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        wr_en_o,
    output logic [N_PORTS-1:0]          grant_o,
    output logic                        busy_o,
    output logic                        proto_err_o
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next;
    logic [PW-1:0] r_grant, r_rr_ptr, w_winner, w_rd_port;
    logic r_pend, r_first, r_proto_err;
    logic w_any, w_rd, w_pend_n, w_tail_seen;
    logic [DATA_W-1:0] w_flit;
    logic [N_PORTS-1:0] w_one;
    assign w_one = {{(N_PORTS-1){1'b0}}, 1'b1};
    assign w_flit = fifo_data_i[int'(r_grant)*DATA_W +: DATA_W];
    assign w_tail_seen = r_pend && w_flit[DATA_W-2];
    // Scan backwards so the last hit is the first non-empty port at or after rr_ptr.
    always_comb begin
        w_any = 1'b0;
        w_winner = r_rr_ptr;
        for (int i = N_PORTS-1; i >= 0; i--) begin
            if (!fifo_empty_i[(int'(r_rr_ptr)+i) % N_PORTS]) begin
                w_any = 1'b1;
                w_winner = PW'((int'(r_rr_ptr)+i) % N_PORTS);
            end
        end
    end
    always_comb begin
        w_next = r_state;
        w_rd = 1'b0;
        w_pend_n = 1'b0;
        w_rd_port = r_grant;
        if (r_state == IDLE) begin
            if (w_any && ready_i) begin
                w_rd = 1'b1;
                w_pend_n = 1'b1;
                w_rd_port = w_winner;
                w_next = BUSY;
            end
        end else if (w_tail_seen) begin
            w_next = IDLE;
        end else if (!fifo_empty_i[r_grant] && ready_i) begin
            w_rd = 1'b1;
            w_pend_n = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_pend <= 1'b0;
            r_rr_ptr <= '0;
            r_first <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend <= w_pend_n;
            if (r_state == IDLE && w_rd) begin
                r_grant <= w_winner;
                r_first <= 1'b1;
            end else if (r_pend) begin
                r_first <= 1'b0;
            end
            if (r_state == BUSY && w_tail_seen)
                r_rr_ptr <= (r_grant == PW'(N_PORTS-1)) ? '0 : r_grant + 1'b1;
            // Heads must open a packet; body/tail must not.
            if (r_pend && (r_first ? !w_flit[DATA_W-1] : w_flit[DATA_W-1]))
                r_proto_err <= 1'b1;
        end
    end
    assign fifo_rd_en_o = (w_rd && !rst_i) ? w_one << w_rd_port : '0;
    assign wr_en_o = r_pend && !rst_i;
    assign data_o = wr_en_o ? w_flit : '0;
    assign busy_o = (r_state == BUSY);
    assign grant_o = busy_o ? w_one << r_grant : '0;
    assign proto_err_o = r_proto_err;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed bench with queue-modelled input FIFOs and an output scoreboard.
module tb_fifo_rr_arbiter;
    logic clk = 1'b0;
    logic rst_i, ready_i;
    logic [4:0] fifo_empty_i, fifo_rd_en_o, grant_o;
    logic [39:0] fifo_data_i;
    logic [7:0] data_o;
    logic wr_en_o, busy_o, proto_err_o;
    logic [7:0] fq [5][$];
    logic [7:0] dat [5];
    int sb_p [$];
    logic [7:0] sb_d [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    fifo_rr_arbiter #(.N_PORTS(5), .DATA_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
        .fifo_rd_en_o(fifo_rd_en_o), .ready_i(ready_i), .data_o(data_o), .wr_en_o(wr_en_o),
        .grant_o(grant_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask
    task automatic upd();
        for (int p = 0; p < 5; p++) begin
            fifo_empty_i[p] = (fq[p].size() == 0);
            fifo_data_i[p*8 +: 8] = dat[p];
        end
    endtask
    task automatic push(input int p, input logic [7:0] d);
        fq[p].push_back(d);
    endtask
    task automatic expect_out(input int p, input logic [7:0] d);
        sb_p.push_back(p);
        sb_d.push_back(d);
    endtask
    task automatic clear_fifos();
        for (int p = 0; p < 5; p++) begin
            fq[p].delete();
            dat[p] = 8'h00;
        end
    endtask
    // Called at posedge+1; samples at the falling edge, then advances one cycle.
    task automatic step(input logic [4:0] erd, input logic ewr, input logic eerr);
        logic [4:0] rd;
        int ep;
        logic [7:0] ed;
        upd();
        #4;
        rd = fifo_rd_en_o;
        chk("rd_en", rd, erd);
        chk("wr_en", wr_en_o, ewr);
        chk("proto_err", proto_err_o, eerr);
        if (wr_en_o) begin
            if (sb_d.size() == 0) chk("unexpected_wr", wr_en_o, 0);
            else begin
                ep = sb_p.pop_front();
                ed = sb_d.pop_front();
                chk("data", data_o, ed);
                chk("grant", grant_o, 32'(1) << ep);
            end
        end else chk("data_idle", data_o, 0);
        for (int p = 0; p < 5; p++)
            if (rd[p] && fq[p].size() == 0) chk("underflow", rd[p], 0);
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 5; p++)
            if (rd[p] && fq[p].size() > 0) dat[p] = fq[p].pop_front();
        upd();
    endtask
    initial begin
        rst_i = 1'b1;
        ready_i = 1'b1;
        clear_fifos();
        for (int p = 0; p < 5; p++) push(p, 8'hC0 + 8'(p));
        upd();
        @(posedge clk);
        #1;
        // Reset held with every FIFO non-empty
        step(5'h00, 0, 0);
        step(5'h00, 0, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        ready_i = 1'b0;
        step(5'h00, 0, 0);
        ready_i = 1'b1;
        clear_fifos();
        // Single 4-flit packet on port 2
        push(2, 8'h81); push(2, 8'h02); push(2, 8'h03); push(2, 8'h44);
        expect_out(2, 8'h81); expect_out(2, 8'h02); expect_out(2, 8'h03); expect_out(2, 8'h44);
        step(5'h04, 0, 0); step(5'h04, 1, 0); step(5'h04, 1, 0); step(5'h04, 1, 0);
        step(5'h00, 1, 0); step(5'h00, 0, 0);
        chk("idle_busy", busy_o, 0);
        // rr_ptr now 3: port 3 beats port 2
        push(2, 8'hC2); push(3, 8'hC3);
        expect_out(3, 8'hC3); expect_out(2, 8'hC2);
        step(5'h08, 0, 0); step(5'h00, 1, 0); step(5'h04, 0, 0); step(5'h00, 1, 0); step(5'h00, 0, 0);
        rst_i = 1'b1;
        step(5'h00, 0, 0);
        rst_i = 1'b0;
        // Fairness across ports 0,1,4 from rr_ptr 0
        push(0, 8'hC0); push(0, 8'hC1); push(1, 8'hC2); push(1, 8'hC3); push(4, 8'hC4); push(4, 8'hC5);
        expect_out(0, 8'hC0); expect_out(1, 8'hC2); expect_out(4, 8'hC4);
        expect_out(0, 8'hC1); expect_out(1, 8'hC3); expect_out(4, 8'hC5);
        for (int k = 0; k < 2; k++) begin
            step(5'h01, 0, 0); step(5'h00, 1, 0);
            step(5'h02, 0, 0); step(5'h00, 1, 0);
            step(5'h10, 0, 0); step(5'h00, 1, 0);
        end
        step(5'h00, 0, 0);
        // Lock: port 1 starves mid-packet while port 0 waits
        push(1, 8'h91); push(1, 8'h12);
        expect_out(1, 8'h91); expect_out(1, 8'h12); expect_out(1, 8'h13); expect_out(1, 8'h54);
        expect_out(0, 8'hC7);
        step(5'h02, 0, 0); step(5'h02, 1, 0);
        push(0, 8'hC7);
        step(5'h00, 1, 0); chk("lock_grant", grant_o, 5'h02);
        step(5'h00, 0, 0); chk("lock_grant", grant_o, 5'h02);
        step(5'h00, 0, 0); chk("lock_grant", grant_o, 5'h02);
        push(1, 8'h13); push(1, 8'h54);
        step(5'h02, 0, 0); step(5'h02, 1, 0); step(5'h00, 1, 0);
        step(5'h01, 0, 0); step(5'h00, 1, 0);
        // Backpressure for 4 cycles mid-packet on port 1
        push(1, 8'hA1); push(1, 8'h22); push(1, 8'h23); push(1, 8'h24); push(1, 8'h65);
        expect_out(1, 8'hA1); expect_out(1, 8'h22); expect_out(1, 8'h23);
        expect_out(1, 8'h24); expect_out(1, 8'h65);
        step(5'h02, 0, 0); step(5'h02, 1, 0);
        ready_i = 1'b0;
        step(5'h00, 1, 0); step(5'h00, 0, 0); step(5'h00, 0, 0); step(5'h00, 0, 0);
        ready_i = 1'b1;
        step(5'h02, 0, 0); step(5'h02, 1, 0); step(5'h02, 1, 0); step(5'h00, 1, 0); step(5'h00, 0, 0);
        // Second head on port 3 raises a sticky protocol error
        push(3, 8'h81); push(3, 8'h82); push(3, 8'h43);
        expect_out(3, 8'h81); expect_out(3, 8'h82); expect_out(3, 8'h43);
        step(5'h08, 0, 0); step(5'h08, 1, 0); step(5'h08, 1, 0); step(5'h00, 1, 1); step(5'h00, 0, 1);
        step(5'h00, 0, 1);
        rst_i = 1'b1;
        step(5'h00, 0, 1);
        rst_i = 1'b0;
        step(5'h00, 0, 0);
        // Reset mid-packet drops the in-flight head
        push(0, 8'h80); push(0, 8'h01);
        step(5'h01, 0, 0);
        rst_i = 1'b1;
        step(5'h00, 0, 0);
        rst_i = 1'b0;
        ready_i = 1'b0;
        step(5'h00, 0, 0);
        chk("midrst_grant", grant_o, 0);
        chk("sb_drain", sb_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
